// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID pipeline register for the RV32I core.
// Holds the PC, selects the next PC, addresses instruction memory and registers the fetched word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [1:0]  pcsrcE,
  input  logic [31:0] pctargetE,
  input  logic [31:0] aluresultE,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JALR   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;

  logic [31:0] w_pcplus4F;
  logic [31:0] w_target;
  logic        w_redirect;

  assign w_pcplus4F = r_pc + 32'd4;

  // Targets are word-aligned: the core has no compressed instructions, so bit 1 is dropped too.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_redirect = 1'b0;
    w_target   = w_pcplus4F;
    case (pcsrc_e'(pcsrcE))
      PCSRC_BRANCH: begin
        w_redirect = 1'b1;
        w_target   = pctargetE & ~32'h3;
      end
      PCSRC_JALR: begin
        w_redirect = 1'b1;
        w_target   = aluresultE & ~32'h3;
      end
      PCSRC_SEQ, PCSRC_RSVD: begin
        w_redirect = 1'b0;
        w_target   = w_pcplus4F;
      end
      default: begin
        w_redirect = 1'b0;
        w_target   = w_pcplus4F;
      end
    endcase
  end

  // A redirect beats stallF: a taken branch must not be lost behind a load-use stall.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N)          r_pc <= RESET_PC;
    else if (w_redirect) r_pc <= w_target;
    else if (!stallF)    r_pc <= w_pcplus4F;
  end

  // A flush only has to kill the instruction, so pcD/pcplus4D keep their last values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_instr     <= NOP_INSTR;
      r_pc_d      <= RESET_PC;
      r_pcplus4_d <= RESET_PC + 32'd4;
      r_valid_d   <= 1'b0;
    end else if (flushD) begin
      r_instr   <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (!stallD) begin
      r_instr     <= imem_rdata;
      r_pc_d      <= r_pc;
      r_pcplus4_d <= w_pcplus4F;
      r_valid_d   <= 1'b1;
    end
  end

  assign pcF       = r_pc;
  assign imem_addr = r_pc;
  assign instrD    = r_instr;
  assign pcD       = r_pc_d;
  assign pcplus4D  = r_pcplus4_d;
  assign validD    = r_valid_d;

endmodule
